timer_bridge: RTL and testbench

Two-master access controller for the pair of interval timers on the device bus. It arbitrates CPU (master 0) and secondary requester (master 1, debug/DMA) accesses onto one shared timer register port, sequences each access through a fixed three-state transfer, and returns read data. It also latches the two timer interrupt lines into sticky pending bits for the interrupt input of the CPU.

---
 rtl/timer_bridge_pkg.sv | 36 +++
 rtl/timer_bridge_if.sv | 21 ++
 rtl/timer_bridge_rr_arb2.sv | 37 +++
 rtl/timer_bridge.sv | 140 ++++++++++++++
 tb/tb_timer_bridge.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module  : timer_bridge_pkg
// Brief   : Shared types and register-map constants for the timer bridge.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package timer_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int TIMER_SEL_BIT = 4;
    localparam int ADDR_LSB      = 2;

    // Which pending bit an access clears: only a write to a timer's ctrl register.
    function automatic logic [1:0] ctrl_clear_mask(input logic we, input logic [2:0] addr);
        logic [1:0] mask;
        mask = 2'b00;
        if (we && addr[1:0] == REG_CTRL) begin
            mask[addr[TIMER_SEL_BIT-ADDR_LSB]] = 1'b1;
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_bridge_if.sv
//------------------------------------------------------------------------------
// Module  : timer_bridge_if
// Brief   : One requester port of the timer bridge (req/ack word access).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface timer_bridge_if;
    logic        req;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, we, wdata, input  ack, rdata);
    modport slave  (input  req, addr, we, wdata, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/timer_bridge_rr_arb2.sv
//------------------------------------------------------------------------------
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter; priority flips to the loser on grant.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    // A grant to master 0 hands priority to master 1 and vice versa.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (advance && (|grant)) begin
            r_prio <= grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_bridge.sv
//------------------------------------------------------------------------------
// Module  : timer_bridge
// Brief   : Arbitrates two masters onto the shared timer register port and
//           latches the timer interrupts into sticky pending bits.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module timer_bridge
    import timer_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    timer_bridge_if.slave m0,
    timer_bridge_if.slave m1,
    output logic [1:0]   dev_addr,
    output logic [31:0]  dev_wdata,
    output logic         dev_we0,
    output logic         dev_we1,
    input  logic [31:0]  dev_rdata0,
    input  logic [31:0]  dev_rdata1,
    input  logic         irq0,
    input  logic         irq1,
    output logic [1:0]   hwint
);

    localparam int c_sel_idx = TIMER_SEL_BIT - ADDR_LSB;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_owner;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [1:0]  r_pend;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_start;
    logic [1:0]  w_clr;
    logic [31:0] w_dev_rdata;
    logic        w_we0;
    logic        w_we1;
    logic        w_ack0;
    logic        w_ack1;

    assign w_req   = {m1.req, m0.req};
    assign w_start = (r_state == IDLE) && (|w_req);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (w_req),
        .advance (w_start),
        .grant   (w_grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_next = ISSUE;
            ISSUE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_we0  = 1'b0;
        w_we1  = 1'b0;
        w_ack0 = 1'b0;
        w_ack1 = 1'b0;
        case (r_state)
            ISSUE: begin
                if (r_we) begin
                    if (r_addr[c_sel_idx]) w_we1 = 1'b1;
                    else                   w_we0 = 1'b1;
                end
            end
            RESP: begin
                if (r_owner) w_ack1 = 1'b1;
                else         w_ack0 = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_dev_rdata = r_addr[c_sel_idx] ? dev_rdata1 : dev_rdata0;
    assign w_clr       = (r_state == ISSUE) ? ctrl_clear_mask(r_we, r_addr) : 2'b00;

    // Transfer registers stay loaded after the access so the device port holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= 3'd0;
            r_we     <= 1'b0;
            r_wdata  <= 32'd0;
            r_owner  <= 1'b0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
            r_pend   <= 2'b00;
        end else begin
            if (w_start) begin
                r_owner <= w_grant[1];
                r_addr  <= w_grant[1] ? m1.addr  : m0.addr;
                r_we    <= w_grant[1] ? m1.we    : m0.we;
                r_wdata <= w_grant[1] ? m1.wdata : m0.wdata;
            end
            if (r_state == ISSUE) begin
                if (r_owner) r_rdata1 <= w_dev_rdata;
                else         r_rdata0 <= w_dev_rdata;
            end
            // A still-asserted level wins over a same-cycle clear.
            r_pend <= {irq1, irq0} | (r_pend & ~w_clr);
        end
    end

    assign dev_addr  = r_addr[1:0];
    assign dev_wdata = r_wdata;
    assign dev_we0   = w_we0;
    assign dev_we1   = w_we1;
    assign m0.ack    = w_ack0;
    assign m1.ack    = w_ack1;
    assign m0.rdata  = r_rdata0;
    assign m1.rdata  = r_rdata1;
    assign hwint     = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_timer_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_timer_bridge
// Brief   : Directed self-checking bench for timer_bridge with a transaction model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_timer_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we0;
    logic        dev_we1;
    logic [31:0] dev_rdata0;
    logic [31:0] dev_rdata1;
    logic        irq0 = 1'b0;
    logic        irq1 = 1'b0;
    logic [1:0]  hwint;

    timer_bridge_if m0_if();
    timer_bridge_if m1_if();

    timer_bridge dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_we0    (dev_we0),
        .dev_we1    (dev_we1),
        .dev_rdata0 (dev_rdata0),
        .dev_rdata1 (dev_rdata1),
        .irq0       (irq0),
        .irq1       (irq1),
        .hwint      (hwint)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Simple timer pair: ctrl/preset/count, count decrements every clock, reg 3 reads 0.
    logic [31:0] t0 [4] = '{default: 32'd0};
    logic [31:0] t1 [4] = '{default: 32'd0};

    always @(posedge clk) begin
        t0[2] <= t0[2] - 32'd1;
        t1[2] <= t1[2] - 32'd1;
        if (dev_we0 && dev_addr != 2'd3) t0[dev_addr] <= dev_wdata;
        if (dev_we1 && dev_addr != 2'd3) t1[dev_addr] <= dev_wdata;
    end

    assign dev_rdata0 = t0[dev_addr];
    assign dev_rdata1 = t1[dev_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 device access, 2 response.
    int          m_phase = 0;
    logic        m_prio  = 1'b0;
    logic        m_win   = 1'b0;
    logic        m_we    = 1'b0;
    logic [2:0]  m_addr  = 3'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rd0   = 32'd0;
    logic [31:0] m_rd1   = 32'd0;
    logic [1:0]  m_pend  = 2'b00;
    logic [1:0]  m_clr;

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_phase = 0; m_prio = 1'b0; m_win = 1'b0; m_we = 1'b0;
            m_addr = 3'd0; m_wdata = 32'd0; m_rd0 = 32'd0; m_rd1 = 32'd0;
            m_pend = 2'b00;
        end else begin
            m_clr = 2'b00;
            if (m_phase == 1 && m_we && m_addr[1:0] == 2'd0) m_clr[m_addr[2]] = 1'b1;
            m_pend = {irq1, irq0} | (m_pend & ~m_clr);
            if (m_phase == 0) begin
                if (m0_if.req || m1_if.req) begin
                    m_win  = (m0_if.req && m1_if.req) ? m_prio : m1_if.req;
                    m_prio = ~m_win;
                    m_addr  = m_win ? m1_if.addr  : m0_if.addr;
                    m_we    = m_win ? m1_if.we    : m0_if.we;
                    m_wdata = m_win ? m1_if.wdata : m0_if.wdata;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_win) m_rd1 = m_addr[2] ? t1[m_addr[1:0]] : t0[m_addr[1:0]];
                else       m_rd0 = m_addr[2] ? t1[m_addr[1:0]] : t0[m_addr[1:0]];
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("dev_we0",  dev_we0,   reset_n && m_phase == 1 && m_we && !m_addr[2]);
        chk("dev_we1",  dev_we1,   reset_n && m_phase == 1 && m_we &&  m_addr[2]);
        chk("m0_ack",   m0_if.ack, reset_n && m_phase == 2 && !m_win);
        chk("m1_ack",   m1_if.ack, reset_n && m_phase == 2 &&  m_win);
        chk("dev_addr", dev_addr,  reset_n ? m_addr[1:0] : 2'd0);
        chk("dev_wdata", dev_wdata, reset_n ? m_wdata : 32'd0);
        chk("m0_rdata", m0_if.rdata, reset_n ? m_rd0 : 32'd0);
        chk("m1_rdata", m1_if.rdata, reset_n ? m_rd1 : 32'd0);
        chk("hwint",    hwint,     reset_n ? m_pend : 2'b00);
    end

    int          we0_cnt = 0;
    int          we1_cnt = 0;
    int          ack0_cnt = 0;
    logic [1:0]  we_addr = 2'd0;
    logic [31:0] we_data = 32'd0;

    initial forever begin
        @(negedge clk);
        if (dev_we0) begin
            we0_cnt++;
            we_addr = dev_addr;
            we_data = dev_wdata;
        end
        if (dev_we1) we1_cnt++;
        if (m0_if.ack) ack0_cnt++;
    end

    task automatic drive(input int m, input logic r, input logic [2:0] a,
                         input logic w, input logic [31:0] wd);
        if (m == 0) begin
            m0_if.req = r; m0_if.addr = a; m0_if.we = w; m0_if.wdata = wd;
        end else begin
            m1_if.req = r; m1_if.addr = a; m1_if.we = w; m1_if.wdata = wd;
        end
    endtask

    task automatic access(input int m, input logic [2:0] a, input logic w,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
        bit done;
        done = 1'b0;
        lat  = 0;
        rd   = 32'd0;
        @(negedge clk);
        drive(m, 1'b1, a, w, wd);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if ((m == 0 && m0_if.ack) || (m == 1 && m1_if.ack)) begin
                done = 1'b1;
                rd = (m == 1) ? m1_if.rdata : m0_if.rdata;
            end
        end
        if (!done) chk("ack_timeout", 32'd0, 32'd1);
        drive(m, 1'b0, a, w, wd);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1);
    end

    int          lat;
    logic [31:0] rd;
    int          w0, w1, a0, nack;
    int          seq [4];
    int          tcy [4];

    initial begin
        drive(0, 1'b0, 3'd0, 1'b0, 32'd0);
        drive(1, 1'b0, 3'd0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_hwint", hwint, 2'b00);
        chk("reset_acks", {m1_if.ack, m0_if.ack}, 2'b00);
        chk("reset_dev_we", {dev_we1, dev_we0}, 2'b00);
        reset_n = 1'b1;

        // Single write to timer 0 preset
        w0 = we0_cnt; w1 = we1_cnt;
        access(0, 3'b001, 1'b1, 32'h0000_0010, lat, rd);
        chk("wr_latency", lat, 2);
        chk("wr_we0_cycles", we0_cnt - w0, 1);
        chk("wr_we1_cycles", we1_cnt - w1, 0);
        chk("wr_dev_addr", we_addr, 2'd1);
        chk("wr_dev_wdata", we_data, 32'h10);

        // Timer 1 preset, then m1 reads it back
        access(0, 3'b101, 1'b1, 32'h55, lat, rd);
        a0 = ack0_cnt;
        access(1, 3'b101, 1'b0, 32'd0, lat, rd);
        chk("rd_m1_rdata", rd, 32'h55);
        chk("rd_latency", lat, 2);
        chk("rd_no_m0_ack", ack0_cnt - a0, 0);

        // Count register read reflects the value during the access cycle
        access(0, 3'b010, 1'b1, 32'h1000, lat, rd);
        access(0, 3'b010, 1'b0, 32'd0, lat, rd);
        chk("count_read", rd, 32'hFFE);

        // Reserved register: write is still strobed, read returns 0
        w0 = we0_cnt;
        access(0, 3'b011, 1'b1, 32'hDEAD_BEEF, lat, rd);
        chk("rsvd_strobe", we0_cnt - w0, 1);
        access(1, 3'b011, 1'b0, 32'd0, lat, rd);
        chk("rsvd_rdata", rd, 32'd0);

        // Contention: both held, grants alternate starting with m0
        nack = 0;
        @(negedge clk);
        drive(0, 1'b1, 3'b001, 1'b0, 32'd0);
        drive(1, 1'b1, 3'b101, 1'b0, 32'd0);
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(negedge clk);
            if (m0_if.ack) begin
                seq[nack] = 0; tcy[nack] = cyc; nack++;
                chk("cont_m0_rdata", m0_if.rdata, 32'h10);
            end else if (m1_if.ack) begin
                seq[nack] = 1; tcy[nack] = cyc; nack++;
                chk("cont_m1_rdata", m1_if.rdata, 32'h55);
            end
        end
        drive(0, 1'b0, 3'b001, 1'b0, 32'd0);
        drive(1, 1'b0, 3'b101, 1'b0, 32'd0);
        #1;
        chk("cont_ack_count", nack, 4);
        for (int k = 0; k < 4 && k < nack; k++) chk("cont_ack_order", seq[k], k % 2);
        for (int k = 1; k < 4 && k < nack; k++) chk("cont_ack_spacing", tcy[k] - tcy[k-1], 3);

        // Interrupt pending: set, set-wins over clear, clear, stays clear
        @(negedge clk);
        irq0 = 1'b1;
        #1;
        chk("irq_hwint_lag", hwint, 2'b00);
        @(negedge clk);
        #1;
        chk("irq_hwint_set", hwint, 2'b01);
        access(0, 3'b000, 1'b1, 32'h8, lat, rd);
        chk("irq_set_wins", hwint, 2'b01);
        @(negedge clk);
        irq0 = 1'b0;
        access(0, 3'b000, 1'b1, 32'h0, lat, rd);
        chk("irq_cleared", hwint, 2'b00);
        repeat (3) @(negedge clk);
        #1;
        chk("irq_stays_clear", hwint, 2'b00);
        @(negedge clk);
        irq1 = 1'b1;
        @(negedge clk);
        irq1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("irq1_sticky", hwint, 2'b10);

        // Reset in the middle of a write
        @(negedge clk);
        drive(0, 1'b1, 3'b001, 1'b1, 32'hAB);
        @(posedge clk);
        #2;
        chk("mid_we0_before", dev_we0, 1'b1);
        a0 = ack0_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_we0_async", dev_we0, 1'b0);
        chk("mid_hwint", hwint, 2'b00);
        chk("mid_acks", {m1_if.ack, m0_if.ack}, 2'b00);
        drive(0, 1'b0, 3'b001, 1'b1, 32'hAB);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_no_ack", ack0_cnt - a0, 0);
        w0 = we0_cnt;
        access(0, 3'b001, 1'b1, 32'hAB, lat, rd);
        chk("reissue_latency", lat, 2);
        chk("reissue_we0", we0_cnt - w0, 1);
        access(1, 3'b001, 1'b0, 32'd0, lat, rd);
        chk("reissue_readback", rd, 32'hAB);

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
